// File: rtl/shift_rows_stream.sv
`default_nettype none
// ============================================================================
// Module   : shift_rows_stream
// Brief    : Column-serial double-buffered (Inv)ShiftRows engine, NB = 4/6/8.
//            Optional per-block bypass via SHIFT_ROWS_STREAM_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module shift_rows_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int NB         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*DATA_WIDTH-1:0] in_col,
  input  logic                    in_inv,
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
  input  logic                    in_bypass,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*DATA_WIDTH-1:0] out_col,
  output logic                    out_last
);

  localparam int               CW       = 4 * DATA_WIDTH;
  localparam int               COL_W    = $clog2(NB);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NB - 1);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_stream: NB must be 4, 6 or 8");
    end
  endgenerate

  logic [1:0]       state_q [2];
  logic [1:0]       state_d [2];
  logic             inv_q   [2];
  logic             inv_d   [2];
  logic             byp_q   [2];
  logic             byp_d   [2];
  logic [CW-1:0]    mem_q   [2][NB];
  logic [CW-1:0]    mem_d   [2][NB];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [COL_W-1:0] wr_col_q,  wr_col_d;
  logic [COL_W-1:0] rd_col_q,  rd_col_d;
  logic             wr_fire, rd_fire, bypass_in;

`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
  assign bypass_in = in_bypass;
`else
  assign bypass_in = 1'b0;
`endif

  // Source column for row r of output column c (row offsets 0,1,3,4 when NB=8).
  function automatic logic [COL_W-1:0] src_col(input int r, input logic [COL_W-1:0] c,
                                               input logic inv, input logic byp);
    int off;
    int s;
    off = (NB == 8 && r >= 2) ? r + 1 : r;
    if (byp)      s = int'(c);
    else if (inv) s = (int'(c) - off + NB) % NB;
    else          s = (int'(c) + off) % NB;
    return COL_W'(s);
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '{ST_EMPTY, ST_EMPTY};
      inv_q     <= '{1'b0, 1'b0};
      byp_q     <= '{1'b0, 1'b0};
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_col_q  <= '0;
      rd_col_q  <= '0;
    end else begin
      state_q   <= state_d;
      inv_q     <= inv_d;
      byp_q     <= byp_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_col_q  <= wr_col_d;
      rd_col_q  <= rd_col_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Handshake outputs depend on registered bank state only
  always_comb begin
    in_ready  = (state_q[wr_bank_q] == ST_EMPTY) || (state_q[wr_bank_q] == ST_FILLING);
    out_valid = (state_q[rd_bank_q] == ST_FULL)  || (state_q[rd_bank_q] == ST_DRAINING);
    out_last  = out_valid && (rd_col_q == LAST_COL);
    wr_fire   = in_valid && in_ready;
    rd_fire   = out_valid && out_ready;
  end

  // Next-state: a bank cannot be written and read in the same cycle because
  // the write side only targets EMPTY/FILLING and the read side FULL/DRAINING.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      if (wr_fire && (wr_bank_q == 1'(b)))
        state_d[b] = (wr_col_q == LAST_COL) ? ST_FULL : ST_FILLING;
      if (rd_fire && (rd_bank_q == 1'(b)))
        state_d[b] = out_last ? ST_EMPTY : ST_DRAINING;
    end
  end

  always_comb begin
    mem_d     = mem_q;
    inv_d     = inv_q;
    byp_d     = byp_q;
    wr_bank_d = wr_bank_q;
    wr_col_d  = wr_col_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    if (wr_fire) begin
      mem_d[wr_bank_q][wr_col_q] = in_col;
      if (wr_col_q == '0) begin
        inv_d[wr_bank_q] = in_inv;
        byp_d[wr_bank_q] = bypass_in;
      end
      if (wr_col_q == LAST_COL) begin
        wr_col_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_col_d  = wr_col_q + COL_W'(1);
      end
    end
    if (rd_fire) begin
      if (out_last) begin
        rd_col_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_col_d  = rd_col_q + COL_W'(1);
      end
    end
  end

  always_comb begin
    out_col = '0;
    if (out_valid) begin
      for (int r = 0; r < 4; r++) begin
        out_col[DATA_WIDTH*r +: DATA_WIDTH] =
          mem_q[rd_bank_q][src_col(r, rd_col_q, inv_q[rd_bank_q], byp_q[rd_bank_q])]
               [DATA_WIDTH*r +: DATA_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_stream.sv
`default_nettype none
// Testbench for shift_rows_stream: NB=4 and NB=8 instances, queue scoreboard
// fed by a row-rotation reference model, decoupled negedge monitors.
module tb_shift_rows_stream;

  typedef struct {
    logic [31:0] col;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv4, iv8, ir4, ir8, ov4, ov8, or4, or8, ol4, ol8, inv, byp;
  logic [31:0] icol, oc4, oc8;

  exp_t        q4[$];
  exp_t        q8[$];
  int          hs_cyc4[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          acc4  = 0;
  bit          drv_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  shift_rows_stream #(.DATA_WIDTH(8), .NB(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_col(icol), .in_inv(inv),
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
    .in_bypass(byp),
`endif
    .out_valid(ov4), .out_ready(or4), .out_col(oc4), .out_last(ol4));

  shift_rows_stream #(.DATA_WIDTH(8), .NB(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_col(icol), .in_inv(inv),
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
    .in_bypass(byp),
`endif
    .out_valid(ov8), .out_ready(or8), .out_col(oc8), .out_last(ol8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: out[r][c] = in[r][(c +/- off_r) mod nb]
  function automatic void push_model(input int nb, input bit is_inv, input logic [31:0] blk[$]);
    exp_t e;
    for (int c = 0; c < nb; c++) begin
      e.col = '0;
      for (int r = 0; r < 4; r++) begin
        int off;
        int src;
        off = (nb == 8 && r >= 2) ? r + 1 : r;
        src = is_inv ? (c - off + nb) % nb : (c + off) % nb;
        e.col[8*r +: 8] = blk[src][8*r +: 8];
      end
      e.last = (c == nb - 1);
      if (nb == 8) q8.push_back(e);
      else         q4.push_back(e);
    end
  endfunction

  // Sends ncols columns; a complete block (ncols == nb) is pushed to the scoreboard.
  task automatic send_block(input int nb, input bit is_inv, input bit pattern, input int ncols);
    logic [31:0] blk[$];
    logic [31:0] col;
    int          tmo;
    for (int c = 0; c < ncols; c++) begin
      col = pattern ? {8'(4*c+3), 8'(4*c+2), 8'(4*c+1), 8'(4*c)} : 32'($urandom);
      blk.push_back(col);
      icol = col;
      inv  = (c == 0) ? is_inv : 1'($urandom);
      if (nb == 8) iv8 = 1'b1;
      else         iv4 = 1'b1;
      tmo = 0;
      while (!((nb == 8) ? ir8 : ir4)) begin
        @(negedge clk);
        tmo++;
        if (tmo > 500) begin
          n_cmp++; n_bad++;
          $display("FAIL in_ready_timeout: got 0 expected 1 (nb=%0d col=%0d)", nb, c);
          iv4 = 1'b0; iv8 = 1'b0;
          return;
        end
      end
      if (c == nb - 1 && ncols == nb) push_model(nb, is_inv, blk);
      @(negedge clk);
      if (nb == 4) acc4++;
    end
    iv4 = 1'b0;
    iv8 = 1'b0;
  endtask

  task automatic wait_drain();
    int tmo;
    tmo = 0;
    while (q4.size() != 0 || q8.size() != 0) begin
      @(negedge clk);
      tmo++;
      if (tmo > 1000) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q4.size(), q8.size());
        q4.delete(); q8.delete();
        return;
      end
    end
    @(negedge clk);
  endtask

  logic [31:0] hold_col4;
  logic        hold_last4;
  bit          hold4 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold4 = 1'b0;
    end else begin
      if (hold4 && ov4) begin
        check("hold_col4", oc4, hold_col4);
        check("hold_last4", 32'(ol4), 32'(hold_last4));
      end
      hold4      = ov4 && !or4;
      hold_col4  = oc4;
      hold_last4 = ol4;
      if (!ov4) check("idle_col4", oc4, 32'h0);
      if (ov4 && or4) begin
        hs_cyc4.push_back(cyc);
        if (q4.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out4: got %h expected no output", oc4);
        end else begin
          e = q4.pop_front();
          check("out_col4", oc4, e.col);
          check("out_last4", 32'(ol4), 32'(e.last));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!ov8) check("idle_col8", oc8, 32'h0);
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out8: got %h expected no output", oc8);
        end else begin
          e = q8.pop_front();
          check("out_col8", oc8, e.col);
          check("out_last8", 32'(ol8), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    rst = 1'b1; iv4 = 1'b0; iv8 = 1'b0; or4 = 1'b1; or8 = 1'b1;
    inv = 1'b0; byp = 1'b0; icol = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready4", 32'(ir4), 32'd1);
    check("rst_out_valid4", 32'(ov4), 32'd0);
    check("rst_out_last4", 32'(ol4), 32'd0);
    check("rst_out_col4", oc4, 32'h0);
    check("rst_in_ready8", 32'(ir8), 32'd1);
    @(negedge clk);

    // NB=4 forward / inverse on the counting pattern, with latency check
    send_block(4, 1'b0, 1'b1, 4);
    check("latency_fwd4", 32'(ov4), 32'd1);
    wait_drain();
    send_block(4, 1'b1, 1'b1, 4);
    check("latency_inv4", 32'(ov4), 32'd1);
    wait_drain();

    // NB=8 forward pattern, then random inverse
    send_block(8, 1'b0, 1'b1, 8);
    check("latency_fwd8", 32'(ov8), 32'd1);
    wait_drain();
    send_block(8, 1'b1, 1'b0, 8);
    wait_drain();

    // Three back-to-back blocks: 12 outputs on consecutive cycles
    base = hs_cyc4.size();
    send_block(4, 1'b0, 1'b0, 4);
    send_block(4, 1'b1, 1'b0, 4);
    send_block(4, 1'b0, 1'b0, 4);
    wait_drain();
    if (hs_cyc4.size() >= base + 12)
      check("b2b_span", 32'(hs_cyc4[base+11] - hs_cyc4[base]), 32'd11);
    else
      check("b2b_count", 32'(hs_cyc4.size() - base), 32'd12);

    // Backpressure: both banks fill, then in_ready drops
    or4 = 1'b0;
    base = acc4;
    drv_done = 1'b0;
    fork
      begin
        send_block(4, 1'b1, 1'b0, 4);
        send_block(4, 1'b0, 1'b0, 4);
        send_block(4, 1'b1, 1'b0, 4);
        drv_done = 1'b1;
      end
    join_none
    repeat (20) @(negedge clk);
    check("bp_accepted", 32'(acc4 - base), 32'd8);
    check("bp_in_ready", 32'(ir4), 32'd0);
    or4 = 1'b1;
    for (int i = 0; i < 200 && !drv_done; i++) @(negedge clk);
    check("bp_driver_done", 32'(drv_done), 32'd1);
    wait_drain();

    // Random out_ready with random blocks
    drv_done = 1'b0;
    fork
      begin
        while (!drv_done) begin
          or4 = 1'($urandom_range(0, 2) != 0);
          @(negedge clk);
        end
        or4 = 1'b1;
      end
    join_none
    for (int i = 0; i < 10; i++) send_block(4, 1'($urandom), 1'b0, 4);
    drv_done = 1'b1;
    @(negedge clk);
    or4 = 1'b1;
    wait_drain();

    // Reset mid-block, then a fresh block must come out clean
    send_block(4, 1'b0, 1'b0, 2);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(ov4), 32'd0);
    check("midrst_in_ready", 32'(ir4), 32'd1);
    check("midrst_out_last", 32'(ol4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_block(4, 1'b0, 1'b1, 4);
    check("post_rst_latency", 32'(ov4), 32'd1);
    wait_drain();
    check("post_rst_out_valid", 32'(ov4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
